// File: rtl/sdsu_bus_slave.sv
// Register-file slave on the SDSU bus: 32 x DATA_W array, one write and one read per accepted cycle.
// Read data and the completion flag are registered; a same-address read returns the incoming write data.
module sdsu_bus_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              valid,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0] WData,
  input  logic [ADDR_W-1:0] RAddr,
  output logic [DATA_W-1:0] RData,
  output logic              ready,
  input  logic              rst_n
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: every rising edge with valid=1 is an accepted transaction (no backpressure);
  // ready is high in the cycle after each accepted edge, and RData is valid in that same cycle.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b0;
        if (valid) state_next = ACK;
      end
      ACK: begin
        ready = 1'b1;
        if (valid) state_next = ACK;
      end
      default: begin
        state_next = IDLE;
        ready      = 1'b0;
      end
    endcase
  end

  // Write-first: a read of the address being written returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RData <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (valid) begin
      mem[WAddr] <= WData;
      RData      <= (RAddr == WAddr) ? WData : mem[RAddr];
    end
  end

endmodule

// File: tb/tb_sdsu_bus_slave.sv
// Directed bench for sdsu_bus_slave: reset, write/read, back-to-back, ignored writes, bypass, mid-stream reset.
module tb_sdsu_bus_slave;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        ready;

  int checks;
  int errors;

  sdsu_bus_slave dut (
    .clk   (clk),
    .valid (valid),
    .WAddr (waddr),
    .WData (wdata),
    .RAddr (raddr),
    .RData (rdata),
    .ready (ready),
    .rst_n (rst_n)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; applies inputs, lets one rising edge pass, returns at the next falling edge.
  task automatic drive(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    valid = v;
    waddr = wa;
    wdata = wd;
    raddr = ra;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_rdata, input logic exp_ready);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, exp_ready});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr  = '0;

    @(negedge clk);
    expect_out("por", 32'h0, 1'b0);
    rst_n = 1'b1;

    // Fill every entry with a nonzero pattern; same-address read exercises the bypass.
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'hA500_0000 | 32'(a), 5'(a));
      expect_out($sformatf("fill%0d", a), 32'hA500_0000 | 32'(a), 1'b1);
    end

    // Asynchronous reset between edges clears outputs immediately.
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read back every address; each cycle writes 0 to the already-read previous address.
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'((a + 31) % 32), 32'h0, 5'(a));
      expect_out($sformatf("rst_rd%0d", a), 32'h0, 1'b1);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0);
    expect_out("idle_after_scan", 32'h0, 1'b0);

    // Write then read
    drive(1'b1, 5'd1, 32'd12345, 5'd0);
    expect_out("wr1", 32'h0, 1'b1);
    drive(1'b1, 5'd3, 32'h0, 5'd1);
    expect_out("rd1", 32'd12345, 1'b1);

    // Back-to-back, then drop valid
    drive(1'b1, 5'd2, 32'd54321, 5'd16);
    expect_out("b2b_wr2", 32'h0, 1'b1);
    drive(1'b1, 5'd4, 32'h0, 5'd2);
    expect_out("b2b_rd2", 32'd54321, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 5'd0);
    expect_out("drop1", 32'd54321, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd0);
    expect_out("drop2", 32'd54321, 1'b0);

    // Ignored writes
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'd1, 5'd0);
      expect_out($sformatf("ign%0d", k), 32'd54321, 1'b0);
    end
    drive(1'b1, 5'd5, 32'h0, 5'd0);
    expect_out("ign_rd0", 32'h0, 1'b1);

    // Bypass and overwrite
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7);
    expect_out("byp7", 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 5'd7, 32'h1, 5'd8);
    expect_out("ovw7_rd8", 32'h0, 1'b1);
    drive(1'b1, 5'd9, 32'h0, 5'd7);
    expect_out("rd7", 32'h1, 1'b1);

    // Reset mid-stream
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31);
    expect_out("wr31", 32'hFFFF_FFFF, 1'b1);
    drive(1'b1, 5'd10, 32'h0, 5'd31);
    expect_out("rd31", 32'hFFFF_FFFF, 1'b1);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_out("pulse_rst", 32'h0, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    expect_out("post_pulse", 32'h0, 1'b0);
    drive(1'b1, 5'd0, 32'h0, 5'd31);
    expect_out("rd31_after_rst", 32'h0, 1'b1);
    drive(1'b1, 5'd0, 32'h0, 5'd7);
    expect_out("rd7_after_rst", 32'h0, 1'b1);

    // Pending write discarded when reset lands before its edge
    valid = 1'b1;
    waddr = 5'd12;
    wdata = 32'h1234_5678;
    raddr = 5'd12;
    #2 rst_n = 1'b0;
    valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    expect_out("discard_idle", 32'h0, 1'b0);
    drive(1'b1, 5'd0, 32'h0, 5'd12);
    expect_out("discard_rd12", 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
